// File: rtl/packed_requantize.sv
// Requantizes packed 2W-bit accumulators to W-bit saturated values, one element per clock.
// Optional fused ReLU: define PACKED_REQUANTIZE_RELU_EN.
module packed_requantize #(
    parameter int unsigned W     = 16,
    parameter int unsigned D     = 16,
    parameter int unsigned SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2*D*W-1:0] packed_in,
    input  logic             in_v,
    output logic [D*W-1:0]   packed_out,
    output logic             out_v,
    output logic             busy
);

    localparam int unsigned IdxW = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned AccW = 2 * W;

    localparam logic signed [AccW-1:0] SatMax = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin = {{(W + 1){1'b1}}, {(W - 1){1'b0}}};
    localparam logic [W-1:0]           OutMax = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0]           OutMin = {1'b1, {(W - 1){1'b0}}};

    typedef enum logic [0:0] {
        StIdle,
        StProc
    } state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                in_v_prev_q, in_v_prev_d;
    logic [2*D*W-1:0]    hold_q, hold_d;
    logic [D*W-1:0]      shadow_q, shadow_d;
    logic [D*W-1:0]      out_q, out_d;
    logic                out_v_q, out_v_d;
    logic                busy_q, busy_d;

    logic [AccW-1:0]        acc;
    logic signed [AccW-1:0] acc_s;
    logic signed [AccW-1:0] shifted;
    logic [W-1:0]           sat_res;
    logic [W-1:0]           res;
    logic                   last;
    logic                   accept;

    // Shared datapath: select the element addressed by idx from the holding register.
    always_comb begin
        acc = '0;
        for (int k = 0; k < D; k++) begin
            if (idx_q == IdxW'(k)) begin
                acc = hold_q[(D - 1 - k) * AccW +: AccW];
            end
        end
    end

    always_comb begin
        acc_s   = acc;
        shifted = acc_s >>> SHIFT;
        if (shifted > SatMax) begin
            sat_res = OutMax;
        end else if (shifted < SatMin) begin
            sat_res = OutMin;
        end else begin
            sat_res = shifted[W-1:0];
        end
    end

`ifdef PACKED_REQUANTIZE_RELU_EN
    always_comb begin
        res = sat_res[W-1] ? '0 : sat_res;
    end
`else
    always_comb begin
        res = sat_res;
    end
`endif

    assign last   = (idx_q == IdxW'(D - 1));
    assign accept = in_v && !in_v_prev_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        in_v_prev_d = in_v;
        hold_d      = hold_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_v_d     = 1'b0;
        busy_d      = busy_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    hold_d  = packed_in;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StProc;
                end
            end
            StProc: begin
                for (int k = 0; k < D; k++) begin
                    if (idx_q == IdxW'(k)) begin
                        shadow_d[(D - 1 - k) * W +: W] = res;
                    end
                end
                if (last) begin
                    // Whole vector published on one edge, final element merged in.
                    out_d   = shadow_d;
                    out_v_d = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            in_v_prev_q <= 1'b0;
            hold_q      <= '0;
            shadow_q    <= '0;
            out_q       <= '0;
            out_v_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_v_prev_q <= in_v_prev_d;
            hold_q      <= hold_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_v_q     <= out_v_d;
            busy_q      <= busy_d;
        end
    end

    assign packed_out = out_q;
    assign out_v      = out_v_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_packed_requantize.sv
// Self-checking bench for packed_requantize: per-cycle model comparison plus directed literals.
module tb_packed_requantize;

    localparam int W     = 16;
    localparam int D     = 16;
    localparam int SHIFT = 8;
    localparam int VW    = D * W;
    localparam int AW    = 2 * D * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_v = 1'b0;
    logic [AW-1:0] packed_in = '0;
    logic [VW-1:0] packed_out;
    logic          out_v;
    logic          busy;

    always #5 clk = ~clk;

    packed_requantize #(
        .W     (W),
        .D     (D),
        .SHIFT (SHIFT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .packed_in  (packed_in),
        .in_v       (in_v),
        .packed_out (packed_out),
        .out_v      (out_v),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rq(input logic [2*W-1:0] a);
        longint v, mx, mn;
        v  = longint'($signed(a));
        v  = v >>> SHIFT;
        mx = (longint'(1) <<< (W - 1)) - 1;
        mn = -(longint'(1) <<< (W - 1));
        if (v > mx) v = mx;
        if (v < mn) v = mn;
`ifdef PACKED_REQUANTIZE_RELU_EN
        if (v < 0) v = 0;
`endif
        return v[W-1:0];
    endfunction

    function automatic logic [VW-1:0] rq_vec(input logic [AW-1:0] p);
        logic [VW-1:0] r;
        r = '0;
        for (int k = 0; k < D; k++) begin
            r[(D - 1 - k) * W +: W] = rq(p[(D - 1 - k) * 2 * W +: 2 * W]);
        end
        return r;
    endfunction

    // Transaction-level model: a vector is accepted on an idle rising edge and
    // appears, fully formed, D edges later.
    logic          m_prev, m_outv, m_busy;
    int            m_cnt;
    logic [VW-1:0] m_vec, m_out;

    always @(posedge clk) begin
        if (rst) begin
            m_prev <= 1'b0;
            m_cnt  <= 0;
            m_out  <= '0;
            m_vec  <= '0;
            m_outv <= 1'b0;
            m_busy <= 1'b0;
        end else begin
            m_prev <= in_v;
            m_outv <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_out  <= m_vec;
                    m_outv <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (in_v && !m_prev) begin
                m_vec  <= rq_vec(packed_in);
                m_cnt  <= D;
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_v", VW'(out_v), VW'(m_outv));
            chk("busy", VW'(busy), VW'(m_busy));
            chk("packed_out", packed_out, m_out);
        end
    end

    // Pulse in_v for one cycle; report edges from accept to out_v and busy cycle count.
    task automatic pulse_and_wait(input logic [AW-1:0] vec, output int lat, output int bcnt);
        @(posedge clk);
        #1 packed_in = vec;
        in_v = 1'b1;
        @(posedge clk);
        #1 in_v = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (out_v) begin
                lat = k - 1;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (out_v) n++;
        end
    endtask

    logic [AW-1:0] va, vb, vc, vd, vs;
    logic [VW-1:0] e;
    int            lat, bcnt, n;

    initial begin
        va = '0;
        va[AW-1 -: 32] = 32'h0000_1234;

        vs = '0;
        vs[AW-1 -: 32]       = 32'h7FFF_FFFF;
        vs[AW-1-32 -: 32]    = 32'h8000_0000;
        vs[AW-1-64 -: 32]    = 32'hFFFF_0000;
        vs[AW-1-96 -: 32]    = 32'hFFFF_FFFF;
        vs[AW-1-128 -: 32]   = 32'h0000_7F80;
        vs[AW-1-160 -: 32]   = 32'hFFFF_FF7F;
        vs[AW-1-192 -: 32]   = 32'h0080_0000;
        vs[AW-1-224 -: 32]   = 32'hFF7F_FFFF;

        vb = '0;
        vc = '0;
        vd = '0;
        for (int k = 0; k < D; k++) begin
            vb[(D - 1 - k) * 2 * W +: 2 * W] = 32'h0000_0100 * (k + 1);
            vc[(D - 1 - k) * 2 * W +: 2 * W] = 32'h0001_0000;
            vd[(D - 1 - k) * 2 * W +: 2 * W] = 32'h0002_0000;
        end

        // Reset
        rst = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_packed_out", packed_out, '0);
        chk("reset_busy", VW'(busy), '0);
        chk("reset_out_v", VW'(out_v), '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic path
        pulse_and_wait(va, lat, bcnt);
        chk("basic_latency", VW'(lat), VW'(16));
        chk("basic_busy_cycles", VW'(bcnt), VW'(16));
        e = '0;
        e[VW-1 -: W] = 16'h0012;
        chk("basic_value", packed_out, e);

        // Saturation and floor
        pulse_and_wait(vs, lat, bcnt);
        chk("sat_latency", VW'(lat), VW'(16));
`ifdef PACKED_REQUANTIZE_RELU_EN
        chk("sat_elems", VW'(packed_out[VW-1 -: 128]), VW'(128'h7FFF_0000_0000_0000_007F_0000_7FFF_0000));
`else
        chk("sat_elems", VW'(packed_out[VW-1 -: 128]), VW'(128'h7FFF_8000_FF00_FFFF_007F_FFFF_7FFF_8000));
`endif

        // Level input: one result per rising edge, then a second after a 1-cycle drop
        @(posedge clk);
        #1 packed_in = va;
        in_v = 1'b1;
        count_pulses(100, n);
        chk("level_one_pulse", VW'(n), VW'(1));
        @(posedge clk);
        #1 in_v = 1'b0;
        @(posedge clk);
        #1 packed_in = vb;
        in_v = 1'b1;
        count_pulses(40, n);
        chk("level_second_pulse", VW'(n), VW'(1));
        @(posedge clk);
        #1 in_v = 1'b0;

        // Rising edge while busy is dropped; input changes are ignored
        @(posedge clk);
        #1 packed_in = vc;
        in_v = 1'b1;
        @(posedge clk);
        #1 in_v = 1'b0;
        repeat (4) @(posedge clk);
        #1 in_v = 1'b1;
        packed_in = vd;
        @(posedge clk);
        #1 in_v = 1'b0;
        count_pulses(40, n);
        chk("busy_edge_ignored", VW'(n), VW'(1));
        chk("busy_hold_value", packed_out, {D{16'h0100}});

        // Rising edge on the completion edge is ignored
        @(posedge clk);
        #1 packed_in = va;
        in_v = 1'b1;
        @(posedge clk);
        #1 in_v = 1'b0;
        packed_in = vd;
        repeat (15) @(posedge clk);
        #1 in_v = 1'b1;
        count_pulses(40, n);
        chk("completion_edge_ignored", VW'(n), VW'(1));
        @(posedge clk);
        #1 in_v = 1'b0;

        // Reset mid-operation aborts the vector
        @(posedge clk);
        #1 packed_in = vb;
        in_v = 1'b1;
        @(posedge clk);
        #1 in_v = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        count_pulses(30, n);
        chk("abort_no_out_v", VW'(n), '0);
        chk("abort_packed_out", packed_out, '0);
        chk("abort_busy", VW'(busy), '0);
        pulse_and_wait(va, lat, bcnt);
        chk("after_reset_latency", VW'(lat), VW'(16));
        chk("after_reset_value", packed_out, e);

`ifdef PACKED_REQUANTIZE_RELU_EN
        vs = '0;
        vs[AW-1 -: 32]    = 32'hFFFF_0000;
        vs[AW-1-32 -: 32] = 32'h0000_0500;
        pulse_and_wait(vs, lat, bcnt);
        chk("relu_elems", VW'(packed_out[VW-1 -: 32]), VW'(32'h0000_0005));
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
